ifq_line_buffer: RTL
====================

IFQ_LINE_BUFFER -- requirements
Module: ifq_line_buffer

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, meaning 32-bit instruction words per fetched memory line (power of 2, 2..8).
REQ-002 SHALL have parameter DEPTH, default 4, meaning line entries held in the queue (power of 2, 2..16).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have port d_valid  input  1  meaning mem_data holds the line for the outstanding request.
REQ-006 SHALL have port mem_data  input  32*LINE_WORDS  meaning the fetched line, word 0 in bits [31:0].
REQ-007 SHALL have port m_rd_en  output  1  meaning a line read request is outstanding.
REQ-008 SHALL have port mem_addr  output  32  meaning the line-aligned byte address of the outstanding request.
REQ-009 SHALL have port abort  output  1  meaning the outstanding request is cancelled this cycle.
REQ-010 SHALL have port jump_branch_valid  input  1  meaning redirect fetch to jump_branch_add.
REQ-011 SHALL have port jump_branch_add  input  32  meaning the redirect target byte address.
REQ-012 SHALL have port d_rd_en  input  1  meaning the dispatcher consumes the current instruction.
REQ-013 SHALL have port empty  output  1  meaning no valid instruction is available.
REQ-014 SHALL have port i_code  output  32  meaning the current instruction word.
REQ-015 SHALL have port pc_out  output  32  meaning the byte address of i_code.
REQ-016 SHALL have port line_count  output  $clog2(DEPTH)+1  meaning occupied line entries.

Function
REQ-017 SHALL implement a two-state fetch FSM, IDLE and REQ; m_rd_en = (state==REQ); mem_addr driven from a registered fetch_pc.
REQ-018 SHALL go IDLE->REQ when line_count < DEPTH and jump_branch_valid=0.
REQ-019 SHALL, in REQ with d_valid=1 and no jump, write mem_data to the entry at wr_ptr, increment wr_ptr (mod DEPTH), add 4*LINE_WORDS to fetch_pc, and stay in REQ if the next-cycle line_count < DEPTH, else go IDLE.
REQ-020 SHALL hold mem_addr stable while m_rd_en=1 until d_valid or abort.
REQ-021 SHALL drive i_code combinationally from entry rd_ptr, word rd_ofs; pc_out is a register advancing by 4 per consumed word.
REQ-022 SHALL, on d_rd_en=1 with empty=0, increment rd_ofs; when rd_ofs = LINE_WORDS-1, pop the line (rd_ptr+1, rd_ofs=0).
REQ-023 SHALL ignore d_rd_en while empty=1.
REQ-024 SHALL assert empty when line_count = 0.
REQ-025 SHALL update line_count correctly on simultaneous push and pop (net unchanged), including push into a full-minus-pop queue.
REQ-026 SHALL drive abort = jump_branch_valid AND (state==REQ), combinationally, for exactly that cycle.
REQ-027 SHALL, on jump_branch_valid, next cycle: flush all entries (line_count=0, pointers 0), set fetch_pc = jump_branch_add with low $clog2(4*LINE_WORDS) bits cleared, set rd_ofs = jump_branch_add word-in-line index, set pc_out = jump_branch_add with bits [1:0] cleared, enter IDLE.
REQ-028 SHALL discard d_valid arriving in the same cycle as jump_branch_valid.
REQ-029 SHALL give jump_branch_valid priority over d_rd_en in the same cycle.

Reset
REQ-030 SHALL, while rst=0, force state=IDLE, fetch_pc=0, pc_out=0, pointers/rd_ofs/line_count=0, m_rd_en=0, empty=1, abort=0 (i_code undefined).
REQ-031 SHALL, on reset mid-request, drop m_rd_en immediately and ignore any later d_valid for that request.

Verification
REQ-032 SHALL verify: release rst -> next cycle m_rd_en=1, mem_addr=0x0; d_valid with words 0x00000013,0x00100093,0x00200113,0x00300193 -> empty=0, i_code=0x00000013, pc_out=0x0, mem_addr=0x10.
REQ-033 SHALL verify: no reads, serve 4 requests -> line_count=4, m_rd_en=0; consume 4 words -> m_rd_en=1, mem_addr=0x40.
REQ-034 SHALL verify: jump to 0x108 while m_rd_en=1 -> abort=1 same cycle; next cycle empty=1; then mem_addr=0x100; after fill i_code=word 2, pc_out=0x108.
REQ-035 SHALL verify: d_rd_en=1 while empty=1 -> pc_out, line_count unchanged.
REQ-036 SHALL verify: d_valid and jump_branch_valid in same cycle -> line discarded, line_count=0, next mem_addr = target line.
REQ-037 SHALL verify: rst=0 while m_rd_en=1 -> m_rd_en=0 before next clk edge, empty=1.

Source files
------------

// File: rtl/ifq_line_buffer.sv
// ============================================================================
//  Module   : ifq_line_buffer
//  Brief    : Instruction fetch queue that requests whole memory lines and
//             hands out one 32-bit instruction word at a time.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifq_line_buffer #(
   parameter int LINE_WORDS = 4,
   parameter int DEPTH      = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        d_valid,
   input  logic [32*LINE_WORDS-1:0]    mem_data,
   output logic                        m_rd_en,
   output logic [31:0]                 mem_addr,
   output logic                        abort,
   input  logic                        jump_branch_valid,
   input  logic [31:0]                 jump_branch_add,
   input  logic                        d_rd_en,
   output logic                        empty,
   output logic [31:0]                 i_code,
   output logic [31:0]                 pc_out,
   output logic [$clog2(DEPTH):0]      line_count
);

   localparam int PW         = $clog2(DEPTH);
   localparam int OW         = $clog2(LINE_WORDS);
   localparam int LINE_BYTES = 4 * LINE_WORDS;
   localparam int OB         = $clog2(LINE_BYTES);

   localparam logic [PW:0]   c_DEPTH     = (PW+1)'(DEPTH);
   localparam logic [OW-1:0] c_LAST_WORD = OW'(LINE_WORDS - 1);
   localparam logic [31:0]   c_LINE_MASK = ~32'(LINE_BYTES - 1);

   typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

   state_t                    r_state;
   logic [31:0]               r_fetch_pc;
   logic [31:0]               r_pc_out;
   logic [PW-1:0]             r_wr_ptr;
   logic [PW-1:0]             r_rd_ptr;
   logic [OW-1:0]             r_rd_ofs;
   logic [PW:0]               r_count;
   logic [32*LINE_WORDS-1:0]  r_mem [DEPTH];

   logic                      w_push;
   logic                      w_consume;
   logic                      w_pop;
   logic [PW:0]               w_count_nxt;

   // A redirect wins over everything: it discards a returning line and any consume.
   assign w_push    = (r_state == S_REQ) && d_valid && !jump_branch_valid;
   assign w_consume = d_rd_en && (r_count != '0) && !jump_branch_valid;
   assign w_pop     = w_consume && (r_rd_ofs == c_LAST_WORD);

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop)
         w_count_nxt = r_count + 1'b1;
      else if (!w_push && w_pop)
         w_count_nxt = r_count - 1'b1;
   end

   assign m_rd_en    = (r_state == S_REQ);
   assign mem_addr   = r_fetch_pc;
   assign abort      = jump_branch_valid && (r_state == S_REQ);
   assign empty      = (r_count == '0);
   assign pc_out     = r_pc_out;
   assign line_count = r_count;
   assign i_code     = r_mem[r_rd_ptr][{r_rd_ofs, 5'b00000} +: 32];

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= mem_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_fetch_pc <= '0;
         r_pc_out   <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_rd_ofs   <= '0;
         r_count    <= '0;
      end else if (jump_branch_valid) begin
         r_state    <= S_IDLE;
         r_fetch_pc <= jump_branch_add & c_LINE_MASK;
         r_pc_out   <= {jump_branch_add[31:2], 2'b00};
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_rd_ofs   <= jump_branch_add[OB-1:2];
         r_count    <= '0;
      end else begin
         r_count <= w_count_nxt;
         case (r_state)
            S_IDLE: begin
               if (r_count < c_DEPTH)
                  r_state <= S_REQ;
            end
            S_REQ: begin
               if (d_valid) begin
                  r_fetch_pc <= r_fetch_pc + 32'(LINE_BYTES);
                  r_wr_ptr   <= r_wr_ptr + 1'b1;
                  if (w_count_nxt >= c_DEPTH)
                     r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_consume) begin
            r_pc_out <= r_pc_out + 32'd4;
            if (w_pop) begin
               r_rd_ofs <= '0;
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end else begin
               r_rd_ofs <= r_rd_ofs + 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire
